bit_packer: RTL and testbench

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer_pkg.sv | 26 ++
 rtl/bit_packer_ins.sv | 21 ++
 rtl/bit_packer.sv | 118 +++++++++++
 tb/tb_bit_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_packer_pkg.sv
// Shared widths, FSM state type and the pad helper for the bit packer.
package bit_packer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 15;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ACC_W  = 46;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Keep the low n bits of word and force everything above to pad.
  function automatic logic [WORD_W-1:0] pad_word(
    input logic [WORD_W-1:0] word,
    input logic [CNT_W-1:0]  n,
    input logic              pad
  );
    logic [WORD_W-1:0] keep;
    keep = (n >= CNT_W'(WORD_W)) ? '1 : ((WORD_W'(1) << n) - WORD_W'(1));
    return (word & keep) | ({WORD_W{pad}} & ~keep);
  endfunction

endpackage

// File: rtl/bit_packer_ins.sv
// Masks a field to its length and ORs it into the accumulator at bit cnt.
module bit_packer_ins
  import bit_packer_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  acc_new
);

  logic [DATA_W-1:0] mask;
  logic [ACC_W-1:0]  field;

  always_comb begin
    mask    = DATA_W'((17'(1) << len) - 17'(1));
    field   = ACC_W'(data & mask) << cnt;
    acc_new = acc | field;
  end

endmodule

// File: rtl/bit_packer.sv
// Packs variable-length fields into 32-bit words, LSB first, with flush
// support; a flush that overflows one word drains the remainder next cycle.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pushin,
  input  logic [LEN_W-1:0]    lenin,
  input  logic [DATA_W-1:0]   datain,
  input  logic                flush,
  output logic                ready,
  output logic                pushout,
  output logic [WORD_W-1:0]   dataout,
  output logic [CNT_W-1:0]    validout
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              pushout_q, pushout_d;
  logic [WORD_W-1:0] dataout_q, dataout_d;
  logic [CNT_W-1:0]  validout_q, validout_d;

  logic [ACC_W-1:0]  acc_ins;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  new_cnt;
  logic              take;

  bit_packer_ins u_ins (
    .acc     (acc_q),
    .cnt     (cnt_q),
    .len     (lenin),
    .data    (datain),
    .acc_new (acc_ins)
  );

  always_comb begin
    take    = pushin & ready_q;
    acc_sum = take ? acc_ins : acc_q;
    new_cnt = cnt_q + (take ? CNT_W'(lenin) : '0);

    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    pushout_d  = 1'b0;
    dataout_d  = dataout_q;
    validout_d = validout_q;

    unique case (state_q)
      RUN: begin
        if (!ready_q) begin
          // first cycle out of reset: inputs are not yet accepted
          ready_d = 1'b1;
        end else begin
          acc_d = acc_sum;
          cnt_d = new_cnt;
          if (new_cnt >= CNT_W'(WORD_W)) begin
            pushout_d  = 1'b1;
            dataout_d  = acc_sum[WORD_W-1:0];
            validout_d = CNT_W'(WORD_W);
            acc_d      = acc_sum >> WORD_W;
            cnt_d      = new_cnt - CNT_W'(WORD_W);
            if (flush && (new_cnt > CNT_W'(WORD_W))) begin
              state_d = DRAIN;
              ready_d = 1'b0;
            end
          end else if (flush && (new_cnt != '0)) begin
            pushout_d  = 1'b1;
            dataout_d  = pad_word(acc_sum[WORD_W-1:0], new_cnt, PAD_BIT);
            validout_d = new_cnt;
            acc_d      = '0;
            cnt_d      = '0;
          end
        end
      end
      DRAIN: begin
        pushout_d  = 1'b1;
        dataout_d  = pad_word(acc_q[WORD_W-1:0], cnt_q, PAD_BIT);
        validout_d = cnt_q;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = RUN;
        ready_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      acc_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      pushout_q  <= 1'b0;
      dataout_q  <= '0;
      validout_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      pushout_q  <= pushout_d;
      dataout_q  <= dataout_d;
      validout_q <= validout_d;
    end
  end

  assign ready    = ready_q;
  assign pushout  = pushout_q;
  assign dataout  = dataout_q;
  assign validout = validout_q;

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: bit-queue reference model plus directed literal checks,
// two DUTs (pad 0 and pad 1) driven from the same stimulus.
module tb_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flush;

  logic        ready0, pushout0, ready1, pushout1;
  logic [31:0] dataout0, dataout1;
  logic [5:0]  validout0, validout1;

  always #5 clk = ~clk;

  bit_packer #(.PAD_BIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .pushin(pushin), .lenin(lenin), .datain(datain),
    .flush(flush), .ready(ready0), .pushout(pushout0), .dataout(dataout0),
    .validout(validout0)
  );

  bit_packer #(.PAD_BIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .pushin(pushin), .lenin(lenin), .datain(datain),
    .flush(flush), .ready(ready1), .pushout(pushout1), .dataout(dataout1),
    .validout(validout1)
  );

  // reference model state
  bit          q[$];
  logic        exp_po    = 1'b0;
  logic        exp_ready = 1'b0;
  logic [31:0] exp_w0    = '0;
  logic [31:0] exp_w1    = '0;
  logic [5:0]  exp_vo    = '0;
  logic        drain_m   = 1'b0;
  logic        checking  = 1'b0;

  // literal expectations, valid for one sampled cycle
  logic        lit_valid = 1'b0;
  string       lit_name;
  logic        lit_po;
  logic [31:0] lit_w0, lit_w1;
  logic [5:0]  lit_vo;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic emit(input int n);
    logic [31:0] w, keep;
    w    = '0;
    keep = '0;
    for (int i = 0; i < n; i++) begin
      w[i]    = q.pop_front();
      keep[i] = 1'b1;
    end
    exp_w0 = w;
    exp_w1 = w | ~keep;
    exp_vo = 6'(n);
    exp_po = 1'b1;
  endtask

  task automatic cycle(input logic r, input logic p, input logic [3:0] l,
                       input logic [14:0] d, input logic f);
    lit_valid = 1'b0;
    rst    = r;
    pushin = p;
    lenin  = l;
    datain = d;
    flush  = f;
    @(posedge clk);
    exp_po = 1'b0;
    if (!r) begin
      q.delete();
      exp_w0 = '0; exp_w1 = '0; exp_vo = '0;
      exp_ready = 1'b0;
      drain_m = 1'b0;
    end else if (drain_m) begin
      emit(q.size());
      drain_m = 1'b0;
      exp_ready = 1'b1;
    end else if (!exp_ready) begin
      exp_ready = 1'b1;
    end else begin
      if (p) for (int i = 0; i < int'(l); i++) q.push_back(d[i]);
      if (q.size() >= 32 && !f) emit(32);
      else if (f && q.size() > 0) begin
        if (q.size() > 32) begin
          emit(32);
          drain_m = 1'b1;
          exp_ready = 1'b0;
        end else emit(q.size());
      end
    end
    checking = 1'b1;
    #1;
  endtask

  task automatic expect_lit(input string nm, input logic po, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [5:0] vo);
    lit_name  = nm;
    lit_po    = po;
    lit_w0    = w0;
    lit_w1    = w1;
    lit_vo    = vo;
    lit_valid = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("ready",       32'(ready0),    32'(exp_ready));
      chk("pushout",     32'(pushout0),  32'(exp_po));
      chk("dataout",     dataout0,       exp_w0);
      chk("validout",    32'(validout0), 32'(exp_vo));
      chk("ready_p1",    32'(ready1),    32'(exp_ready));
      chk("pushout_p1",  32'(pushout1),  32'(exp_po));
      chk("dataout_p1",  dataout1,       exp_w1);
      chk("validout_p1", 32'(validout1), 32'(exp_vo));
      if (lit_valid) begin
        chk({lit_name, "_pushout"},  32'(pushout0),  32'(lit_po));
        chk({lit_name, "_dataout"},  dataout0,       lit_w0);
        chk({lit_name, "_dataout1"}, dataout1,       lit_w1);
        chk({lit_name, "_validout"}, 32'(validout0), 32'(lit_vo));
        chk({lit_name, "_model"},    exp_w0,         lit_w0);
      end
    end
  end

  initial begin
    rst = 1'b0; pushin = 1'b0; lenin = '0; datain = '0; flush = 1'b0;

    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 8, 15'h0AB, 1);
    expect_lit("reset", 0, 32'h0, 32'h0, 6'd0);
    cycle(1, 0, 0, 0, 0);

    // four bytes into one word
    cycle(1, 1, 8, 15'h0AB, 0);
    cycle(1, 1, 8, 15'h0CD, 0);
    cycle(1, 1, 8, 15'h0EF, 0);
    cycle(1, 1, 8, 15'h012, 0);
    expect_lit("four_bytes", 1, 32'h12EFCDAB, 32'h12EFCDAB, 6'd32);
    cycle(1, 0, 0, 0, 0);

    // 45 ones then flush
    cycle(1, 1, 15, 15'h7FFF, 0);
    cycle(1, 1, 15, 15'h7FFF, 0);
    cycle(1, 1, 15, 15'h7FFF, 0);
    expect_lit("ones_full", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd32);
    cycle(1, 0, 0, 0, 1);
    expect_lit("ones_flush", 1, 32'h00001FFF, 32'hFFFFFFFF, 6'd13);

    // push+flush overflowing a word -> drain cycle, push during drain dropped
    cycle(1, 1, 15, 15'h7FFF, 0);
    cycle(1, 1, 15, 15'h7FFF, 0);
    cycle(1, 1, 15, 15'h0000, 1);
    expect_lit("drain_full", 1, 32'h3FFFFFFF, 32'h3FFFFFFF, 6'd32);
    cycle(1, 1, 8, 15'h0FF, 0);
    expect_lit("drain_rest", 1, 32'h00000000, 32'hFFFFE000, 6'd13);
    cycle(1, 0, 0, 0, 1);
    expect_lit("drop_check", 0, 32'h00000000, 32'hFFFFE000, 6'd13);

    // high datain bits beyond lenin ignored, padding
    cycle(1, 1, 4, 15'h7FF3, 0);
    cycle(1, 0, 0, 0, 1);
    expect_lit("pad", 1, 32'h00000003, 32'hFFFFFFF3, 6'd4);

    // reset mid-accumulation
    cycle(1, 1, 15, 15'h1234, 0);
    cycle(1, 1, 5, 15'h001F, 0);
    cycle(0, 0, 0, 0, 0);
    expect_lit("mid_reset", 0, 32'h0, 32'h0, 6'd0);
    cycle(1, 1, 8, 15'h055, 1);
    cycle(1, 1, 8, 15'h0AB, 0);
    cycle(1, 1, 8, 15'h0CD, 0);
    cycle(1, 1, 8, 15'h0EF, 0);
    cycle(1, 1, 8, 15'h012, 0);
    expect_lit("after_reset", 1, 32'h12EFCDAB, 32'h12EFCDAB, 6'd32);

    // empty flush and zero-length pushes
    cycle(1, 0, 0, 0, 1);
    expect_lit("empty_flush", 0, 32'h12EFCDAB, 32'h12EFCDAB, 6'd32);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 15'($urandom), 0);
    expect_lit("len0", 0, 32'h12EFCDAB, 32'h12EFCDAB, 6'd32);
    cycle(1, 1, 4, 15'h0005, 1);
    expect_lit("cnt_zero", 1, 32'h00000005, 32'hFFFFFFF5, 6'd4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 7),
            4'($urandom),
            15'($urandom),
            ($urandom_range(0, 11) == 0));
    end

    cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
